// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the single-port RAM block.
// SP_RAM_PARITY_EN widens each stored byte lane by one even-parity bit.
package sp_ram_pkg;

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

`ifdef SP_RAM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Storage array: per-lane synchronous write and registered read.
// Lane width comes from sp_ram_pkg (8, or 9 with SP_RAM_PARITY_EN).
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int LANES  = 1,
  parameter int LW     = LANE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [LANES-1:0]      be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [LANES*LW-1:0]   wdata,
  input  logic                  re,
  output logic [LANES*LW-1:0]   rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [LANES*LW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) begin
          mem[addr][i*LW +: LW] <= wdata[i*LW +: LW];
        end
      end
    end
  end

  // Only the output register is reset; the array is cleared by the INIT sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sp_ram_param.sv
// Single-port RAM with valid/ready requests, a clear-on-reset sweep and
// optional per-byte even parity (macro SP_RAM_PARITY_EN).
module sp_ram_param
  import sp_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_busy,
  output logic                par_err
);

  localparam int BE_W    = DATA_W / 8;
  localparam int STORE_W = BE_W * LANE_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic               accept;
  logic               arr_we;
  logic               arr_re;
  logic [BE_W-1:0]    arr_be;
  logic [ADDR_W-1:0]  arr_addr;
  logic [STORE_W-1:0] arr_wdata;
  logic [STORE_W-1:0] store_wdata;
  logic [STORE_W-1:0] store_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = IDLE;
        end
      end
      IDLE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  assign init_busy = (state_q == INIT);
  assign req_ready = !init_busy;
  assign accept    = req_valid && req_ready;

  always_comb begin
    store_wdata = '0;
    for (int i = 0; i < BE_W; i++) begin
`ifdef SP_RAM_PARITY_EN
      store_wdata[i*LANE_W +: LANE_W] = {byte_parity(req_wdata[i*8 +: 8]), req_wdata[i*8 +: 8]};
`else
      store_wdata[i*LANE_W +: LANE_W] = req_wdata[i*8 +: 8];
`endif
    end
  end

  // The sweep owns the array port during INIT; nothing reaches it on a reset edge.
  assign arr_we    = !rst && (init_busy || (accept && req_we));
  assign arr_re    = !rst && accept && !req_we;
  assign arr_be    = init_busy ? '1 : req_be;
  assign arr_addr  = init_busy ? cnt_q : req_addr;
  assign arr_wdata = init_busy ? '0 : store_wdata;

  sp_ram_array #(
    .ADDR_W (ADDR_W),
    .LANES  (BE_W),
    .LW     (LANE_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .rdata (store_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= arr_re;
    end
  end

  always_comb begin
    rsp_rdata = '0;
    for (int i = 0; i < BE_W; i++) begin
      rsp_rdata[i*8 +: 8] = store_rdata[i*LANE_W +: 8];
    end
  end

`ifdef SP_RAM_PARITY_EN
  logic lane_mismatch;

  always_comb begin
    lane_mismatch = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (byte_parity(store_rdata[i*LANE_W +: 8]) != store_rdata[i*LANE_W + 8]) begin
        lane_mismatch = 1'b1;
      end
    end
  end

  assign par_err = rsp_valid && lane_mismatch;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: doc/sp_ram_param.md
SP_RAM_PARAM -- requirements
Module: sp_ram_param

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits, multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words.
REQ-003 Derived constant BE_W = DATA_W/8, byte lanes per word.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  word address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_be  input  BE_W  byte enables; bit i covers bits [8i+7:8i].
REQ-012 rsp_valid  output  1  read data valid, one-cycle pulse per accepted read.
REQ-013 rsp_rdata  output  DATA_W  read data.
REQ-014 init_busy  output  1  memory clear in progress.
REQ-015 par_err  output  1  parity error flag, qualified by rsp_valid.

Function
REQ-016 FSM states: INIT and IDLE; no other states.
- INIT: writes zero to address cnt, then cnt+1, one word per cycle.
- INIT -> IDLE after address DEPTH-1 is written, so INIT lasts exactly DEPTH cycles.
- IDLE: held until rst.
REQ-017 init_busy SHALL be 1 in INIT and 0 in IDLE; req_ready SHALL equal !init_busy.
REQ-018 Accepted write SHALL update only the enabled byte lanes of mem[req_addr] at that edge; req_be = 0 SHALL leave the word unchanged.
REQ-019 Accepted write SHALL produce no response; rsp_valid stays 0.
REQ-020 Accepted read SHALL give rsp_valid = 1 and rsp_rdata = mem[req_addr] on the next cycle (latency 1). Back-to-back reads SHALL sustain one response per cycle.
REQ-021 Read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-022 rsp_rdata SHALL hold its last value while rsp_valid = 0.
REQ-023 Requests presented while req_ready = 0 SHALL be ignored, with no memory or output change.
REQ-024 Address arithmetic SHALL wrap naturally at ADDR_W bits; there is no out-of-range address.

Reset
REQ-025 On rst = 1 at a clock edge, the block SHALL enter INIT with cnt = 0, rsp_valid = 0, rsp_rdata = 0, par_err = 0, init_busy = 1 and req_ready = 0 from the next cycle.
REQ-026 rst asserted mid-INIT SHALL restart the clear from address 0.
REQ-027 rst asserted the cycle after an accepted read SHALL suppress that read's response.
REQ-028 Memory content is not reset directly; it is zero only through the INIT sweep.

Configuration
REQ-029 Macro SP_RAM_PARITY_EN:
- Defined: each byte lane stores one extra even-parity bit, written with its lane and cleared to 0 by INIT. On each read response, par_err = 1 if any lane's stored parity mismatches its stored data.
- Undefined: no parity storage; par_err tied to 0.

Structure
REQ-030 Package sp_ram_pkg SHALL hold the FSM state enum (INIT, IDLE) and the byte-parity function.
REQ-031 Storage SHALL be a sub-module sp_ram_array:
- Synchronous write with per-lane enable; registered read.
- FSM, handshake and parity check stay in sp_ram_param.

Verification
REQ-032 Reset: rst for 1 cycle -> init_busy = 1 for exactly 32 cycles (defaults), then req_ready = 1; a read of every address returns 0x00.
REQ-033 Write/read: write addr 5 data 0xA5, be = 1; next-cycle read of addr 5 -> rsp_valid on the following cycle with 0xA5. A read issued during INIT gets no rsp_valid.
REQ-034 Byte enable (DATA_W = 32): write 0x11223344, be = 4'b1111; then write 0xAABBCCDD, be = 4'b0101 -> read returns 0x11BB33DD.
REQ-035 Reset mid-INIT: rst at INIT cycle 10 -> init_busy stays 1 for 32 further cycles; a write issued during INIT has no effect, checked by a readback of 0x00.
REQ-036 Parity (SP_RAM_PARITY_EN defined): write 0x3C to addr 7, force-flip a stored data bit via hierarchy, read addr 7 -> rsp_valid = 1 with par_err = 1. Without the macro, par_err = 0 throughout.
